// File: rtl/iob_master_ctrl_if.sv
// Requester handshake and I/O-bus signal bundle for the IOB master controller.
// The master modport is the controller; slave is the requester/bus side.
interface iob_master_ctrl_if;
    logic IOREQ;
    logic IORW;
    logic IOL;
    logic IOU;
    logic IOACT;
    logic IOBERR;
    logic nAS_IOB;
    logic nLDS_IOB;
    logic nUDS_IOB;
    logic RnW_IOB;
    logic nDoutOE;
    logic nDinLE;
    logic E_IOB;
    logic nVMA_IOB;
    logic nDTACK_IOB;
    logic nVPA_IOB;
    logic nBERR_IOB;

    modport master (
        input  IOREQ, IORW, IOL, IOU, nDTACK_IOB, nVPA_IOB, nBERR_IOB,
        output IOACT, IOBERR, nAS_IOB, nLDS_IOB, nUDS_IOB, RnW_IOB,
               nDoutOE, nDinLE, E_IOB, nVMA_IOB
    );

    modport slave (
        output IOREQ, IORW, IOL, IOU, nDTACK_IOB, nVPA_IOB, nBERR_IOB,
        input  IOACT, IOBERR, nAS_IOB, nLDS_IOB, nUDS_IOB, RnW_IOB,
               nDoutOE, nDinLE, E_IOB, nVMA_IOB
    );
endinterface

// File: rtl/iob_master_ctrl.sv
// 68000-style I/O-bus master: runs one bus cycle per request, with DTACK,
// 6800-style VPA/VMA and BERR/timeout terminations and a free-running E clock.
module iob_master_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int EDIV    = 10
) (
    input  logic              CLK,
    input  logic              RST,
    iob_master_ctrl_if.master bus
);
    localparam int             ECW     = $clog2(EDIV);
    localparam logic [ECW-1:0] E_LAST  = ECW'(EDIV - 1);
    localparam logic [ECW-1:0] E_HIGH  = ECW'(EDIV - 4);
    localparam logic [ECW-1:0] E_VMA   = ECW'(2);
    localparam logic [ECW-1:0] E_ONE   = ECW'(1);
    localparam logic [7:0]     TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AS, S_STRB, S_WAIT, S_VMA, S_DONE, S_END, S_RECOV
    } state_t;

    state_t         state_r;
    logic [ECW-1:0] ecnt_r;
    logic [ECW-1:0] ecnt_nxt_s;
    logic           e_r;
    logic [2:0]     term_s1_r;   // {nBERR, nDTACK, nVPA}
    logic [2:0]     term_s2_r;
    logic           berr_s, dtack_s, vpa_s;
    logic           armed_r, err_r, lds_en_r, uds_en_r;
    logic [7:0]     wcnt_r;
    logic           ioact_r, ioberr_r, nas_r, nlds_r, nuds_r, rnw_r;
    logic           ndoutoe_r, ndinle_r, nvma_r;

    // Two-flop synchronizers on the asynchronous bus terminations
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            term_s1_r <= 3'b111;
            term_s2_r <= 3'b111;
        end else begin
            term_s1_r <= {bus.nBERR_IOB, bus.nDTACK_IOB, bus.nVPA_IOB};
            term_s2_r <= term_s1_r;
        end
    end

    assign berr_s  = ~term_s2_r[2];
    assign dtack_s = ~term_s2_r[1];
    assign vpa_s   = ~term_s2_r[0];

    // Next E-clock count, wrapping at EDIV-1
    always_comb begin
        if (ecnt_r == E_LAST) begin
            ecnt_nxt_s = '0;
        end else begin
            ecnt_nxt_s = ecnt_r + E_ONE;
        end
    end

    // E is registered from the next count so it is high while Ecnt is in the last four counts
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ecnt_r <= '0;
            e_r    <= 1'b0;
        end else begin
            ecnt_r <= ecnt_nxt_s;
            e_r    <= (ecnt_nxt_s >= E_HIGH);
        end
    end

    // Bus-cycle sequencer; every strobe is a register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= S_IDLE;
            armed_r   <= 1'b0;
            err_r     <= 1'b0;
            lds_en_r  <= 1'b0;
            uds_en_r  <= 1'b0;
            wcnt_r    <= 8'd0;
            ioact_r   <= 1'b0;
            ioberr_r  <= 1'b0;
            nas_r     <= 1'b1;
            nlds_r    <= 1'b1;
            nuds_r    <= 1'b1;
            rnw_r     <= 1'b1;
            ndoutoe_r <= 1'b1;
            ndinle_r  <= 1'b1;
            nvma_r    <= 1'b1;
        end else begin
            // A request must be seen low once before it may start another cycle
            if (!bus.IOREQ) armed_r <= 1'b1;
            case (state_r)
                S_IDLE: begin
                    if (bus.IOREQ && armed_r) begin
                        state_r  <= S_AS;
                        armed_r  <= 1'b0;
                        rnw_r    <= bus.IORW;
                        ioact_r  <= 1'b1;
                        nas_r    <= 1'b0;
                        ioberr_r <= 1'b0;
                        err_r    <= 1'b0;
                    end
                end
                S_AS: begin
                    state_r  <= S_STRB;
                    lds_en_r <= bus.IOL;
                    uds_en_r <= bus.IOU;
                    if (rnw_r) begin
                        nlds_r <= ~bus.IOL;
                        nuds_r <= ~bus.IOU;
                    end else begin
                        ndoutoe_r <= 1'b0;
                    end
                end
                S_STRB: begin
                    state_r <= S_WAIT;
                    wcnt_r  <= 8'd0;
                    if (!rnw_r) begin
                        nlds_r <= ~lds_en_r;
                        nuds_r <= ~uds_en_r;
                    end
                end
                S_WAIT: begin
                    if (berr_s) begin
                        state_r  <= S_DONE;
                        err_r    <= 1'b1;
                        ndinle_r <= ~rnw_r;
                    end else if (dtack_s) begin
                        state_r  <= S_DONE;
                        ndinle_r <= ~rnw_r;
                    end else if (vpa_s) begin
                        state_r <= S_VMA;
                    end else if (wcnt_r == TO_LAST) begin
                        state_r  <= S_DONE;
                        err_r    <= 1'b1;
                        ndinle_r <= ~rnw_r;
                    end else begin
                        wcnt_r <= wcnt_r + 8'd1;
                    end
                end
                S_VMA: begin
                    // Only finish on E falling once VMA has actually been driven
                    if (berr_s) begin
                        state_r  <= S_DONE;
                        err_r    <= 1'b1;
                        nvma_r   <= 1'b1;
                        ndinle_r <= ~rnw_r;
                    end else if (!nvma_r && (ecnt_r == E_LAST)) begin
                        state_r  <= S_DONE;
                        nvma_r   <= 1'b1;
                        ndinle_r <= ~rnw_r;
                    end else if (ecnt_r == E_VMA) begin
                        nvma_r <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_r  <= S_END;
                    ndinle_r <= 1'b1;
                    nas_r    <= 1'b1;
                    nlds_r   <= 1'b1;
                    nuds_r   <= 1'b1;
                    ioact_r  <= 1'b0;
                    ioberr_r <= err_r;
                end
                S_END: begin
                    state_r   <= S_RECOV;
                    ndoutoe_r <= 1'b1;
                    rnw_r     <= 1'b1;
                end
                S_RECOV: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.IOACT    = ioact_r;
    assign bus.IOBERR   = ioberr_r;
    assign bus.nAS_IOB  = nas_r;
    assign bus.nLDS_IOB = nlds_r;
    assign bus.nUDS_IOB = nuds_r;
    assign bus.RnW_IOB  = rnw_r;
    assign bus.nDoutOE  = ndoutoe_r;
    assign bus.nDinLE   = ndinle_r;
    assign bus.E_IOB    = e_r;
    assign bus.nVMA_IOB = nvma_r;
endmodule

// File: tb/tb_iob_master_ctrl.sv
// Bench for iob_master_ctrl: per-cycle comparison against an event-timeline
// model of each transfer, a directed table, reset corner cases and random transfers.
module tb_iob_master_ctrl;
    localparam int TIMEOUT = 255;
    localparam int EDIV    = 10;
    localparam int INF     = 1 << 30;
    // {IOACT, IOBERR, nAS, nLDS, nUDS, RnW, nDoutOE, nDinLE, E, nVMA}
    localparam logic [9:0] RST_VEC = 10'b0011111101;

    typedef struct {
        bit rw;
        bit l;
        bit u;
        int dd;        // cycles after IOACT seen before nDTACK driven low, -1 = never
        int dv;
        int db;
        bit hold;      // keep IOREQ high through the whole cycle
        bit exp_err;
        int exp_dinle;
        bit exp_vma;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    int   ecount = 0;
    int   checks = 0;
    int   failures = 0;

    // Transfer model: edge numbers of the events of the current transfer
    int m_k, m_d, m_s, m_vl;
    bit m_rw, m_l, m_u, m_err;
    bit last_err;

    iob_master_ctrl_if bus_if ();

    iob_master_ctrl #(.TIMEOUT(TIMEOUT), .EDIV(EDIV)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if.master)
    );

    always #5 CLK = ~CLK;

    // Edge index since reset release; the edge numbered e samples Ecnt == e mod EDIV
    always @(posedge CLK) ecount <= RST ? 0 : ecount + 1;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic e_bit(int e);
        return (((e + 1) % EDIV) >= (EDIV - 4));
    endfunction

    function automatic logic [9:0] outs();
        return {bus_if.IOACT, bus_if.IOBERR, bus_if.nAS_IOB, bus_if.nLDS_IOB,
                bus_if.nUDS_IOB, bus_if.RnW_IOB, bus_if.nDoutOE, bus_if.nDinLE,
                bus_if.E_IOB, bus_if.nVMA_IOB};
    endfunction

    function automatic logic [9:0] exp_txn(int e);
        logic act, ber, lds, uds, rnw, doe, dle, vma;
        act = (e >= m_k) && (e <= m_d);
        ber = (e > m_d) ? m_err : 1'b0;
        lds = !(m_l && (e >= m_s) && (e <= m_d));
        uds = !(m_u && (e >= m_s) && (e <= m_d));
        rnw = ((e >= m_k) && (e <= m_d + 1)) ? m_rw : 1'b1;
        doe = !(!m_rw && (e >= m_k + 1) && (e <= m_d + 1));
        dle = !(m_rw && (e == m_d));
        vma = !((e >= m_vl) && (e < m_d));
        return {act, ber, !act, lds, uds, rnw, doe, dle, e_bit(e), vma};
    endfunction

    function automatic vec_t mk(bit rw, bit l, bit u, int dd, int dv, int db, bit hold,
                                bit ee, int ed, bit ev);
        vec_t t;
        t.rw = rw; t.l = l; t.u = u; t.dd = dd; t.dv = dv; t.db = db; t.hold = hold;
        t.exp_err = ee; t.exp_dinle = ed; t.exp_vma = ev;
        return t;
    endfunction

    task automatic check_vec(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s edge=%0d got=%b exp=%b", name, ecount - 1, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s edge=%0d got=%0d exp=%0d", name, ecount - 1, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check_vec("idle", outs(), {1'b0, last_err, 6'b111111, e_bit(ecount - 1), 1'b1});
        end
    endtask

    // Issue one transfer at the next edge, play the bus side, compare every cycle
    task automatic run_txn(input vec_t t, output bit o_err, output int o_dinle, output bit o_vma);
        int eb, ed, ev, ew, v, vend, ab;
        m_k  = ecount;
        m_rw = t.rw;
        m_l  = t.l;
        m_u  = t.u;
        eb = (t.db < 0) ? INF : m_k + 3 + t.db;
        ed = (t.dd < 0) ? INF : m_k + 3 + t.dd;
        ev = (t.dv < 0) ? INF : m_k + 3 + t.dv;
        ew = imin(imin(eb, ed), imin(ev, m_k + 2 + TIMEOUT));
        m_vl  = INF;
        m_err = 1'b0;
        if (ew == eb) begin
            m_d = ew; m_err = 1'b1;
        end else if (ew == ed) begin
            m_d = ew;
        end else if (ew == ev) begin
            v = ew;
            m_vl = v + 1;
            while ((m_vl % EDIV) != 2) m_vl++;
            vend = m_vl + 1;
            while ((vend % EDIV) != EDIV - 1) vend++;
            ab = (eb == INF) ? INF : imax(eb, v + 1);
            if (ab <= vend) begin
                m_d = ab; m_err = 1'b1;
                if (ab <= m_vl) m_vl = INF;
            end else begin
                m_d = vend;
            end
        end else begin
            m_d = ew; m_err = 1'b1;
        end
        m_s = t.rw ? m_k + 1 : m_k + 2;
        o_dinle = 0;
        o_vma   = 1'b0;
        bus_if.IORW  = t.rw;
        bus_if.IOL   = 1'($urandom);
        bus_if.IOU   = 1'($urandom);
        bus_if.IOREQ = 1'b1;
        for (int e = m_k; e <= m_d + 3; e++) begin
            @(negedge CLK);
            check_vec("txn", outs(), exp_txn(e));
            if (!bus_if.nDinLE)   o_dinle++;
            if (!bus_if.nVMA_IOB) o_vma = 1'b1;
            if (e == m_k) begin
                bus_if.IOL  = t.l;
                bus_if.IOU  = t.u;
                bus_if.IORW = ~t.rw;
                if (!t.hold) bus_if.IOREQ = 1'b0;
            end
            if (e <= m_d) begin
                if (t.dd >= 0 && e == m_k + t.dd) bus_if.nDTACK_IOB = 1'b0;
                if (t.dv >= 0 && e == m_k + t.dv) bus_if.nVPA_IOB   = 1'b0;
                if (t.db >= 0 && e == m_k + t.db) bus_if.nBERR_IOB  = 1'b0;
            end
            if (e == m_d + 1) begin
                bus_if.nDTACK_IOB = 1'b1;
                bus_if.nVPA_IOB   = 1'b1;
                bus_if.nBERR_IOB  = 1'b1;
            end
        end
        o_err    = bus_if.IOBERR;
        last_err = m_err;
    endtask

    initial begin
        vec_t vecs[10];
        vec_t t;
        bit   oe;
        int   od;
        bit   ov;

        vecs[0] = mk(1, 1, 1,  2, -1, -1, 0, 0, 1, 0);  // plain read, DTACK
        vecs[1] = mk(0, 1, 0,  0, -1, -1, 0, 0, 0, 0);  // lower-byte write
        vecs[2] = mk(1, 1, 1, -1,  1, -1, 0, 0, 1, 1);  // VPA read
        vecs[3] = mk(0, 0, 1, -1, -1,  3, 0, 1, 0, 0);  // BERR write
        vecs[4] = mk(1, 1, 1,  2,  2, -1, 0, 0, 1, 0);  // DTACK beats VPA
        vecs[5] = mk(1, 1, 0,  1, -1,  1, 0, 1, 1, 0);  // BERR beats DTACK
        vecs[6] = mk(1, 1, 1, -1,  0,  1, 0, 1, 1, 0);  // BERR aborts VMA at once
        vecs[7] = mk(0, 1, 1, -1, -1, -1, 0, 1, 0, 0);  // timeout
        vecs[8] = mk(1, 0, 1,  5, -1, -1, 1, 0, 1, 0);  // clears IOBERR, IOREQ held
        vecs[9] = mk(0, 1, 1, -1,  3, -1, 0, 0, 0, 1);  // VPA write

        RST = 1'b1;
        bus_if.IOREQ = 1'b0;
        bus_if.IORW = 1'b0;
        bus_if.IOL = 1'b0;
        bus_if.IOU = 1'b0;
        bus_if.nDTACK_IOB = 1'b1;
        bus_if.nVPA_IOB = 1'b1;
        bus_if.nBERR_IOB = 1'b1;
        last_err = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_vec("reset", outs(), RST_VEC);
        RST = 1'b0;
        idle_cycles(3);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], oe, od, ov);
            check_int("tbl_err", int'(oe), int'(vecs[i].exp_err));
            check_int("tbl_dinle", od, vecs[i].exp_dinle);
            check_int("tbl_vma", int'(ov), int'(vecs[i].exp_vma));
            if (vecs[i].hold) begin
                idle_cycles(5);
                bus_if.IOREQ = 1'b0;
            end
            idle_cycles(1 + i % 3);
        end

        // Reset while a cycle is stuck in WAIT
        bus_if.IORW = 1'b1;
        bus_if.IOL = 1'b1;
        bus_if.IOU = 1'b1;
        bus_if.IOREQ = 1'b1;
        @(negedge CLK);
        bus_if.IOREQ = 1'b0;
        repeat (6) @(negedge CLK);
        check_vec("wait_busy", outs() & 10'b1010000000, 10'b1000000000);
        RST = 1'b1;
        #1;
        check_vec("rst_mid", outs(), RST_VEC);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        last_err = 1'b0;
        idle_cycles(2);

        for (int i = 0; i < 30; i++) begin
            t.rw = 1'($urandom);
            t.l = 1'($urandom);
            t.u = 1'($urandom);
            t.dd = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 12));
            t.dv = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 12));
            t.db = ($urandom_range(0, 2) != 0) ? -1 : int'($urandom_range(0, 12));
            if (t.dd < 0 && t.dv < 0 && t.db < 0) t.dd = int'($urandom_range(0, 12));
            t.hold = 1'b0;
            run_txn(t, oe, od, ov);
            check_int("rnd_err", int'(oe), int'(m_err));
            check_int("rnd_dinle", od, m_rw ? 1 : 0);
            check_int("rnd_vma", int'(ov), (m_vl != INF) ? 1 : 0);
            idle_cycles(1 + int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
